// File: rtl/sum_sevenseg_driver.sv
// Shows the 6-bit adder result {cout,sum} in decimal on two digits of the Basys-3 display.
// The binary value is converted with a sequential shift/add-3 FSM; the digits are scanned by a refresh counter.
module sum_sevenseg_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int IN_W        = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sum_in,
    input  logic       cout_in,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam int BCD_W = 8;
    localparam int SH_W  = BCD_W + IN_W;
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_busy;

    logic [IN_W-1:0]   r_sync1;
    logic [IN_W-1:0]   r_sync2;
    logic [IN_W-1:0]   w_val_s;
    logic [IN_W-1:0]   r_last;
    logic [SH_W-1:0]   r_shreg;
    logic [SH_W-1:0]   w_shreg_nxt;
    logic [2:0]        r_iter;
    logic [3:0]        r_tens;
    logic [3:0]        r_ones;

    logic [CNT_W-1:0]  r_ref;
    logic              r_digit;
    logic [6:0]        r_seg;
    logic [3:0]        r_an;
    logic [3:0]        w_cur_digit;

    // One double-dabble step: correct each BCD nibble that would overflow on doubling, then shift.
    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] x);
        logic [SH_W-1:0] y;
        y = x;
        if (y[SH_W-1 -: 4] >= 4'd5)
            y[SH_W-1 -: 4] = y[SH_W-1 -: 4] + 4'd3;
        if (y[SH_W-5 -: 4] >= 4'd5)
            y[SH_W-5 -: 4] = y[SH_W-5 -: 4] + 4'd3;
        return {y[SH_W-2:0], 1'b0};
    endfunction

    // Active-low {g,f,e,d,c,b,a}; codes above 9 never occur but are blanked for safety.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Switch-derived inputs are asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {cout_in, sum_in};
            r_sync2 <= r_sync1;
        end
    end

    assign w_val_s     = r_sync2;
    assign w_shreg_nxt = dabble_step(r_shreg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_val_s != r_last)
                    w_next = S_LOAD;
            end
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: begin
                if (r_iter == 3'(IN_W - 1))
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The conversion works on a private copy of val_s, so input changes only show up on the next pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_last  <= '0;
            r_iter  <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shreg <= {{BCD_W{1'b0}}, w_val_s};
                    r_last  <= w_val_s;
                    r_iter  <= '0;
                end
                S_SHIFT: begin
                    r_shreg <= w_shreg_nxt;
                    r_iter  <= r_iter + 3'd1;
                end
                S_DONE: begin
                    r_tens <= r_shreg[SH_W-1 -: 4];
                    r_ones <= r_shreg[SH_W-5 -: 4];
                end
                default: begin
                end
            endcase
        end
    end

    assign w_cur_digit = r_digit ? r_tens : r_ones;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref   <= '0;
            r_digit <= 1'b0;
        end else if (r_ref == CNT_W'(REFRESH_DIV - 1)) begin
            r_ref   <= '0;
            r_digit <= ~r_digit;
        end else begin
            r_ref   <= r_ref + 1'b1;
        end
    end

    // Leading zero in the tens position is blanked by leaving its anode off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= 7'b1111111;
            r_an  <= 4'b1111;
        end else begin
            r_seg <= enc(w_cur_digit);
            if (!r_digit)
                r_an <= 4'b1110;
            else if (r_tens == 4'd0)
                r_an <= 4'b1111;
            else
                r_an <= 4'b1101;
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign dp   = 1'b1;
    assign busy = w_busy;

endmodule
